// File: rtl/regfile_dump_unit_if.sv
// Indexed register-dump beat stream.
// The unit drives beats as master; the debug/trace link consumes them as slave.
interface regfile_dump_unit_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/regfile_dump_unit.sv
// Walks register indices FIRST_REG..LAST_REG through a spare register-file read port.
// Each value is streamed out as an indexed beat while the core is held stalled.
module regfile_dump_unit #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    output logic [4:0]                  rf_addr,
    input  logic [31:0]                 rf_data,
    regfile_dump_unit_if.master         dump_if,
    output logic                        stall_req,
    output logic                        busy,
    output logic                        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  beat_idx_q, beat_idx_d;
    logic [31:0] data_q, data_d;

    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        beat_idx_d = beat_idx_q;
        data_d     = data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = READ;
                end
            end
            READ: begin
                data_d     = rf_data;
                beat_idx_d = idx_q;
                state_d    = SEND;
            end
            SEND: begin
                if (dump_if.dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides any handshake in the same cycle; the beat counts as undelivered.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            beat_idx_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            beat_idx_q <= beat_idx_d;
            data_q     <= data_d;
        end
    end

    // Everything reads as zero in IDLE, even though the data flops keep the last beat.
    assign busy               = (state_q != IDLE);
    assign stall_req          = busy;
    assign done               = (state_q == DONE);
    assign rf_addr            = busy ? idx_q : 5'd0;
    assign dump_if.dump_valid = (state_q == SEND);
    assign dump_if.dump_idx   = busy ? beat_idx_q : 5'd0;
    assign dump_if.dump_data  = busy ? data_q : 32'd0;

endmodule
